// File: rtl/miriscv_pkg.sv
// rtl/miriscv_pkg.sv - shared types and constants for the miriscv fetch stage
package miriscv_pkg;

    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/miriscv_fetch_fifo.sv
// rtl/miriscv_fetch_fifo.sv - synchronous prefetch FIFO with push/pop/flush
module miriscv_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = data_i;
                wptr_d        = wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign data_o  = mem_q[rptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/miriscv_fetch_unit.sv
// rtl/miriscv_fetch_unit.sv - PC generation, imem req/gnt/rvalid, prefetch and redirect (optional MIRISCV_FETCH_BYPASS_EN)
module miriscv_fetch_unit
    import miriscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    output logic            instr_req_o,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_gnt_i,
    input  logic            instr_rvalid_i,
    input  logic [31:0]     instr_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            fetch_valid_o,
    output logic [31:0]     fetch_instr_o,
    output logic [XLEN-1:0] fetch_pc_o,
    input  logic            fetch_ready_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic [XLEN-1:0] redirect_addr_q, redirect_addr_d;
    logic            stale_q, stale_d;
    logic            req_hold_q, req_hold_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_d [DEPTH];
    logic [PW-1:0]   pc_wptr_q, pc_wptr_d;
    logic [PW-1:0]   pc_rptr_q, pc_rptr_d;

    logic                 gnt_fire;
    logic                 rsp_fire;
    logic                 drop;
    logic                 bypass;
    logic                 req_wait;
    logic [XLEN-1:0]      redirect_target;
    logic [XLEN-1:0]      rsp_pc;
    logic [CW:0]          occupancy;
    logic                 room;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [ILEN+XLEN-1:0] fifo_rdata;

    assign gnt_fire        = instr_req_o && instr_gnt_i;
    assign rsp_fire        = instr_rvalid_i && (outstanding_q != '0);
    assign drop            = rsp_fire && (discard_q != '0);
    assign req_wait        = instr_req_o && !instr_gnt_i;
    assign redirect_target = redirect_pc_i & {{(XLEN-2){1'b1}}, 2'b00};
    assign rsp_pc          = pc_mem_q[pc_rptr_q];
    assign occupancy       = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign room            = occupancy < (CW+1)'(DEPTH);

`ifdef MIRISCV_FETCH_BYPASS_EN
    assign bypass = fifo_empty && (discard_q == '0) && rsp_fire;
`else
    assign bypass = 1'b0;
`endif

    // A request caught by a redirect before its grant keeps its address; the
    // redirect target is parked and becomes the next address once it is granted.
    always_comb begin
        outstanding_d   = outstanding_q + CW'(gnt_fire) - CW'(rsp_fire);
        discard_d       = discard_q - CW'(drop);
        fetch_addr_d    = fetch_addr_q;
        redirect_addr_d = redirect_addr_q;
        stale_d         = stale_q;
        req_hold_d      = req_wait;
        if (gnt_fire) begin
            if (stale_q) begin
                fetch_addr_d = redirect_addr_q;
                stale_d      = 1'b0;
            end else begin
                fetch_addr_d = fetch_addr_q + XLEN'(4);
            end
        end
        if (redirect_i) begin
            discard_d = outstanding_d + CW'(req_wait);
            if (req_wait) begin
                stale_d         = 1'b1;
                redirect_addr_d = redirect_target;
            end else begin
                fetch_addr_d = redirect_target;
                stale_d      = 1'b0;
            end
        end
    end

    // Grant-time PC of each outstanding request, retired in response order
    always_comb begin
        pc_mem_d  = pc_mem_q;
        pc_wptr_d = pc_wptr_q;
        pc_rptr_d = pc_rptr_q;
        if (gnt_fire) begin
            pc_mem_d[pc_wptr_q] = fetch_addr_q;
            pc_wptr_d           = pc_wptr_q + PW'(1);
        end
        if (rsp_fire) begin
            pc_rptr_d = pc_rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q         <= S_IDLE;
            fetch_addr_q    <= RESET_PC;
            redirect_addr_q <= RESET_PC;
            stale_q         <= 1'b0;
            req_hold_q      <= 1'b0;
            outstanding_q   <= '0;
            discard_q       <= '0;
            pc_wptr_q       <= '0;
            pc_rptr_q       <= '0;
        end else begin
            state_q         <= state_d;
            fetch_addr_q    <= fetch_addr_d;
            redirect_addr_q <= redirect_addr_d;
            stale_q         <= stale_d;
            req_hold_q      <= req_hold_d;
            outstanding_q   <= outstanding_d;
            discard_q       <= discard_d;
            pc_wptr_q       <= pc_wptr_d;
            pc_rptr_q       <= pc_rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        pc_mem_q <= pc_mem_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:           state_d = S_FETCH;
            S_FETCH, S_FLUSH: state_d = (discard_d != '0) ? S_FLUSH : S_FETCH;
            default:          state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_req_o  = (state_q != S_IDLE) && (room || req_hold_q);
        instr_addr_o = fetch_addr_q;
    end

    assign fifo_pop  = !fifo_empty && fetch_ready_i;
    assign fifo_push = rsp_fire && !drop && !redirect_i && !(bypass && fetch_ready_i)
                       && (!fifo_full || fifo_pop);

    miriscv_fetch_fifo #(
        .WIDTH (ILEN + XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .push_i  (fifo_push),
        .data_i  ({instr_rdata_i, rsp_pc}),
        .pop_i   (fifo_pop),
        .flush_i (redirect_i),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        if (!fifo_empty) begin
            fetch_valid_o = 1'b1;
            fetch_instr_o = fifo_rdata[ILEN+XLEN-1:XLEN];
            fetch_pc_o    = fifo_rdata[XLEN-1:0];
        end else if (bypass) begin
            fetch_valid_o = 1'b1;
            fetch_instr_o = instr_rdata_i;
            fetch_pc_o    = rsp_pc;
        end else begin
            fetch_valid_o = 1'b0;
            fetch_instr_o = NOP_INSTR;
            fetch_pc_o    = fetch_addr_q;
        end
    end

endmodule
